mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds to the CPU data-memory bus alongside the data memory, turning CPU stores into an 8N1 serial stream. An external address decoder asserts `sel` for this block's 16-byte window; the block buffers bytes in a TX FIFO and serializes them at a programmable bit period. Software polls a status register for FIFO space and transmitter activity.

---
 rtl/mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter.
// CPU stores to TXDATA are queued in a small FIFO and shifted out LSB first
// at DIVISOR clocks per bit; STATUS exposes FIFO fill, activity and a sticky
// overflow flag. Only addr[3:2] is decoded; the access size code is ignored.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_DEFAULT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  memOp,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        txd,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, count, count_next;
  logic          fifo_full, fifo_empty;
  logic [15:0]   divisor;
  logic          overflow;
  state_t        state;
  logic [7:0]    shift;
  logic [15:0]   period, bit_cnt;
  logic [2:0]    bit_idx;
  logic          wr_req, push_req, push, pop, bit_end, frame_done, active_next;
  logic [3:0]    count_sat;
  logic [31:0]   rdata;
  logic          unused_bits;

  // Bus fields that carry no meaning for a word-wide register block.
  assign unused_bits = ^{memOp, addr[31:4], addr[1:0], din[31:16]};

  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO
  // is always dropped even while the transmitter frees a slot.
  assign wr_req     = sel & we;
  assign push_req   = wr_req & (addr[3:2] == 2'd0);
  assign push       = push_req & ~fifo_full;
  assign bit_end    = (bit_cnt == period - 16'd1);
  assign frame_done = (state == STOP) & bit_end;
  assign pop        = ~fifo_empty & ((state == IDLE) | frame_done);
  assign count_next = count + CW'(push) - CW'(pop);

  // After this cycle the FSM stays out of IDLE unless it is idle (or just
  // finishing a stop bit) with nothing to pop.
  assign active_next = ~(((state == IDLE) | frame_done) & ~pop);

  // STATUS count field saturates at 15 for deep FIFOs.
  always_comb begin
    count_sat = 4'(count);
    if (32'(count) > 32'd15) count_sat = 4'd15;
  end

  // Read-data mux by register index.
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'd1:    rdata = {24'd0, count_sat, overflow, busy, fifo_empty, fifo_full};
      2'd2:    rdata = {16'd0, divisor};
      default: rdata = 32'd0;
    endcase
  end

  // FIFO storage: written on accepted pushes, no reset needed.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= din[7:0];
  end

  // FIFO pointers; reset discards any queued bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Control registers: sticky overflow and bit-period divisor (minimum 2).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      divisor  <= 16'(DIV_DEFAULT);
    end else begin
      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (wr_req && addr[3:2] == 2'd1)
        overflow <= 1'b0;
      if (wr_req && addr[3:2] == 2'd2)
        divisor <= (din[15:0] < 16'd2) ? 16'd2 : din[15:0];
    end
  end

  // Registered read data, updated only on read accesses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          dout <= 32'd0;
    else if (sel && !we) dout <= rdata;
  end

  // Activity flag: frame pending next cycle or bytes left in the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= 1'b0;
    else        busy <= active_next | (count_next != '0);
  end

  // Transmit FSM; the bit period is latched per frame so DIVISOR writes
  // only take effect from the next start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= 8'd0;
      period  <= 16'd2;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift   <= fifo_mem[rd_ptr[AW-1:0]];
            period  <= divisor;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            txd     <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            txd     <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (pop) begin
              shift   <= fifo_mem[rd_ptr[AW-1:0]];
              period  <= divisor;
              bit_idx <= 3'd0;
              txd     <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx. Stimulus pushes
// expected frames and read values into queues; a serial receiver and a read
// monitor pop and compare independently of the stimulus.
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;
  localparam int DIVD  = 434;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  memOp;
  logic [31:0] din;
  logic [31:0] dout;
  logic        txd;
  logic        busy;

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         contig;
  } frame_t;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_t;

  frame_t exp_q[$];
  rd_t    rd_q[$];
  int     checks   = 0;
  int     failures = 0;
  bit     in_frame = 0;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_DEFAULT(DIVD)) dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .memOp(memOp), .din(din), .dout(dout), .txd(txd), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = ($urandom & 32'hFFFF_FFF0) | {28'd0, idx, 2'b00};
    memOp = 3'($urandom);
    din   = data;
    $display("write reg=%0d din=0x%08h", idx, data);
    @(posedge clock);
    #1;
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus_write(2'd0, ($urandom & 32'hFFFF_FF00) | {24'd0, b});
  endtask

  task automatic bus_read(input logic [1:0] idx, input logic [31:0] expv, input string name);
    rd_t e;
    e.val  = expv;
    e.name = name;
    rd_q.push_back(e);
    sel   = 1'b1;
    we    = 1'b0;
    addr  = ($urandom & 32'hFFFF_FFF0) | {28'd0, idx, 2'b00};
    memOp = 3'($urandom);
    din   = $urandom;
    @(posedge clock);
    #1;
    sel = 1'b0;
  endtask

  function automatic void expect_frame(input logic [7:0] b, input int p, input bit c);
    frame_t f;
    f.data   = b;
    f.p      = p;
    f.contig = c;
    exp_q.push_back(f);
  endfunction

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    @(negedge clock);
    while (busy && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("idle_timeout_busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  // Serial receiver: checks each frame sample-by-sample against the
  // expected 8N1 waveform and rebuilds the byte from mid-bit samples.
  initial begin : frame_mon
    frame_t     cur;
    int         pos, wave_err, cyc, last_end, k;
    logic [7:0] rx;
    logic       expb;
    bit         spurious;
    pos = 0; wave_err = 0; cyc = 0; last_end = -100; rx = 8'd0; spurious = 0;
    cur.data = 8'd0; cur.p = 1; cur.contig = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset !== 1'b1) begin
        in_frame = 0;
        spurious = 0;
        exp_q.delete();
      end else if (spurious) begin
        if (txd === 1'b1) spurious = 0;
      end else begin
        if (!in_frame && txd !== 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start txd=%b at cycle %0d with no frame expected", txd, cyc);
            spurious = 1;
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1;
            pos = 0;
            wave_err = 0;
            rx = 8'd0;
            if (cur.contig) chk("frame_gap", 32'(cyc - last_end - 1), 32'd0);
          end
        end
        if (in_frame) begin
          k = pos / cur.p;
          if (k == 0)      expb = 1'b0;
          else if (k == 9) expb = 1'b1;
          else             expb = cur.data[k-1];
          if (txd !== expb) wave_err++;
          if (k >= 1 && k <= 8 && (pos % cur.p) == cur.p / 2) rx[k-1] = txd;
          pos++;
          if (pos == 10 * cur.p) begin
            in_frame = 0;
            last_end = cyc;
            $display("frame byte=0x%02h expected=0x%02h P=%0d wave_errors=%0d", rx, cur.data, cur.p, wave_err);
            chk("frame_wave", 32'(wave_err), 32'd0);
            chk("frame_byte", {24'd0, rx}, {24'd0, cur.data});
          end
        end
      end
    end
  end

  // Read monitor: one cycle after a sampled read, compare dout.
  initial begin : read_mon
    rd_t e;
    bit  got;
    forever begin
      @(posedge clock);
      got = (reset === 1'b1) && sel && !we;
      @(negedge clock);
      if (got) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read dout=0x%08h with no read expected", dout);
        end else begin
          e = rd_q.pop_front();
          $display("read %s dout=0x%08h expected=0x%08h", e.name, dout, e.val);
          chk(e.name, dout, e.val);
        end
      end
    end
  end

  initial begin : stim
    int         occ, first_low, k, n, dw, p;
    bit         acc, ovf;
    logic [7:0] b;
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 32'd0; memOp = 3'd0; din = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Reset state and idle behaviour.
    idle(100);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dout", dout, 32'd0);
    bus_read(2'd1, 32'h0000_0002, "status_reset");
    bus_read(2'd2, DIVD, "divisor_reset");
    bus_read(2'd0, 32'd0, "txdata_read_zero");
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'd0, "reserved_read_zero");
    bus_read(2'd1, 32'h0000_0002, "status_after_reserved_write");

    // Divisor clamping and field width.
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, 32'd2, "divisor_clamp1");
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, 32'd2, "divisor_clamp0");
    bus_write(2'd2, 32'h0001_0007);
    bus_read(2'd2, 32'd7, "divisor_low16");
    bus_write(2'd2, 32'd4);

    // Single frame at P=4: start one cycle after the push, 40-cycle frame.
    expect_frame(8'hA5, 4, 0);
    push(8'hA5);
    first_low = -1;
    k = 0;
    @(negedge clock);
    while (busy && k < 200) begin
      if (first_low < 0 && txd == 1'b0) first_low = k;
      @(negedge clock);
      k++;
    end
    chk("start_latency", 32'(first_low), 32'd1);
    chk("busy_end_cycle", 32'(k), 32'd41);
    @(posedge clock);
    #1;

    // Back-to-back frames at P=2 must be contiguous.
    bus_write(2'd2, 32'd2);
    expect_frame(8'h55, 2, 0);
    expect_frame(8'h0F, 2, 1);
    push(8'h55);
    push(8'h0F);
    wait_idle(500);
    bus_read(2'd1, 32'h0000_0002, "status_after_pair");

    // Divisor change mid-frame applies to the next frame only.
    bus_write(2'd2, 32'd4);
    expect_frame(8'h3C, 4, 0);
    expect_frame(8'hC3, 8, 1);
    push(8'h3C);
    push(8'hC3);
    idle(5);
    bus_write(2'd2, 32'd8);
    wait_idle(500);
    bus_read(2'd2, 32'd8, "divisor_after_change");

    // Randomized bursts with random divisors.
    for (int it = 0; it < 6; it++) begin
      dw = $urandom_range(0, 6);
      p  = (dw < 2) ? 2 : dw;
      bus_write(2'd2, ($urandom & 32'hFFFF_0000) | 32'(dw));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        expect_frame(b, p, j > 0);
        push(b);
        idle($urandom_range(0, 2));
      end
      wait_idle(1000);
      bus_read(2'd1, 32'h0000_0002, "status_after_burst");
    end

    // Overflow: 10 rapid pushes at P=1000 into an 8-deep FIFO.
    bus_write(2'd2, 32'd1000);
    occ = 0;
    ovf = 0;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 8'h00 : 8'($urandom);
      acc = (occ < DEPTH);
      if (acc) expect_frame(b, 1000, i > 0);
      push(b);
      occ = occ + (acc ? 1 : 0) - ((i == 1) ? 1 : 0);
      ovf = ovf | !acc;
    end
    bus_read(2'd1, {24'd0, 4'(occ), ovf, 1'b1, occ == 0, occ == DEPTH}, "status_overflow");
    bus_write(2'd1, $urandom);
    bus_read(2'd1, {24'd0, 4'(occ), 1'b0, 1'b1, occ == 0, occ == DEPTH}, "status_overflow_cleared");

    // Reset in the middle of the data bits of the 0x00 byte.
    idle(2500);
    chk("txd_mid_data_low", {31'd0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async_reset_txd", {31'd0, txd}, 32'd1);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_dout", dout, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    bus_read(2'd1, 32'h0000_0002, "status_after_reset");
    bus_read(2'd2, DIVD, "divisor_after_reset");
    idle(300);
    chk("post_reset_txd", {31'd0, txd}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    idle(3);
    chk("reads_outstanding", 32'(rd_q.size()), 32'd0);
    chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
    chk("frame_in_progress", {31'd0, in_frame}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
